// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses a zero-latency instruction
// memory and captures the returned word into the IF/ID pipeline register.
module fetch_stage #(
  parameter int unsigned                 PC_WIDTH    = 16,
  parameter int unsigned                 INSTR_WIDTH = 16,
  parameter int unsigned                 PC_STEP     = 1,
  parameter logic [PC_WIDTH-1:0]         RESET_PC    = '0,
  parameter logic [INSTR_WIDTH-1:0]      HALT_INSTR  = '1,
  parameter int unsigned                 CNT_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  input  logic                   stall,
  input  logic                   redirect_valid,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  output logic                   if_valid,
  output logic [INSTR_WIDTH-1:0] if_instr,
  output logic [PC_WIDTH-1:0]    if_pc,
  output logic                   halted,
  output logic [CNT_WIDTH-1:0]   fetch_count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic                   if_valid_q, if_valid_d;
  logic [INSTR_WIDTH-1:0] if_instr_q, if_instr_d;
  logic [PC_WIDTH-1:0]    if_pc_q, if_pc_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

  // State and pipeline registers; reset wins over everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      if_valid_q <= 1'b0;
      if_instr_q <= '0;
      if_pc_q    <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
      cnt_q      <= cnt_d;
    end
  end

  // Next-state logic: redirect beats stall, stall beats fetch.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    cnt_d      = cnt_q;

    if (redirect_valid) begin
      // Flush the wrong-path instruction and restart from the target.
      pc_d       = redirect_pc;
      if_valid_d = 1'b0;
      state_d    = ST_RUN;
    end else if (!stall) begin
      unique case (state_q)
        ST_IDLE: begin
          state_d    = ST_RUN;
          if_valid_d = 1'b0;
        end
        ST_RUN: begin
          if_instr_d = imem_data;
          if_pc_d    = pc_q;
          if_valid_d = 1'b1;
          cnt_d      = cnt_q + CNT_WIDTH'(1);
          if (imem_data == HALT_INSTR) begin
            state_d = ST_HALTED;
          end else begin
            pc_d = pc_q + PC_WIDTH'(PC_STEP);
          end
        end
        ST_HALTED: begin
          // Halt instruction has been accepted; present a bubble from now on.
          if_valid_d = 1'b0;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Output mapping; imem_addr and halted are decoded from registers.
  assign imem_addr   = pc_q;
  assign halted      = (state_q == ST_HALTED);
  assign if_valid    = if_valid_q;
  assign if_instr    = if_instr_q;
  assign if_pc       = if_pc_q;
  assign fetch_count = cnt_q;

endmodule
